// File: rtl/jtkiwi_gfx_pkg.sv
// Shared definitions for the Kiwi GFX read-port arbiter: owner encoding,
// slot-to-owner map and the tag that follows each read down the pipeline.
package jtkiwi_gfx_pkg;

    localparam logic OWN_SCR = 1'b0;
    localparam logic OWN_OBJ = 1'b1;

    typedef struct packed {
        logic active;
        logic owner;
    } arb_tag_t;

    localparam arb_tag_t TAG_IDLE = '{active: 1'b0, owner: OWN_SCR};

    // Slots 0 and 3 belong to the tilemap engine, slots 1 and 2 to objects.
    function automatic logic slot_owner(input logic [1:0] i_slot);
        return (i_slot == 2'd1 || i_slot == 2'd2) ? OWN_OBJ : OWN_SCR;
    endfunction

endpackage

// File: rtl/jtkiwi_arb_rdpipe.sv
// Read-return pipeline for the GFX arbiter. The tag of a granted read is
// delayed two clocks so it lines up with the synchronous RAM output, then the
// RAM data is captured into the tagged owner's registers and that owner's
// valid pulses for one clock. Data holds until the owner's next valid.
module jtkiwi_arb_rdpipe
    import jtkiwi_gfx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  arb_tag_t    i_tag,
    input  logic [15:0] i_code,
    input  logic [7:0]  i_lut,
    output logic        o_scr_valid,
    output logic [15:0] o_scr_code,
    output logic [7:0]  o_scr_lut,
    output logic        o_obj_valid,
    output logic [15:0] o_obj_code,
    output logic [7:0]  o_obj_lut
);

    arb_tag_t    r_tag0;
    arb_tag_t    r_tag1;
    logic        r_scr_valid;
    logic        r_obj_valid;
    logic [15:0] r_scr_code;
    logic [15:0] r_obj_code;
    logic [7:0]  r_scr_lut;
    logic [7:0]  r_obj_lut;
    logic        w_cap_scr;
    logic        w_cap_obj;

    assign w_cap_scr = r_tag1.active && (r_tag1.owner == OWN_SCR);
    assign w_cap_obj = r_tag1.active && (r_tag1.owner == OWN_OBJ);

    // Tag shift register: stage 0 pairs with the address stage, stage 1 with RAM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag0 <= TAG_IDLE;
            r_tag1 <= TAG_IDLE;
        end else begin
            r_tag0 <= i_tag;
            r_tag1 <= r_tag0;
        end
    end

    // Capture RAM data for the tagged owner and raise its valid for one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scr_valid <= 1'b0;
            r_obj_valid <= 1'b0;
            r_scr_code  <= '0;
            r_scr_lut   <= '0;
            r_obj_code  <= '0;
            r_obj_lut   <= '0;
        end else begin
            r_scr_valid <= w_cap_scr;
            r_obj_valid <= w_cap_obj;
            if (w_cap_scr) begin
                r_scr_code <= i_code;
                r_scr_lut  <= i_lut;
            end
            if (w_cap_obj) begin
                r_obj_code <= i_code;
                r_obj_lut  <= i_lut;
            end
        end
    end

    assign o_scr_valid = r_scr_valid;
    assign o_scr_code  = r_scr_code;
    assign o_scr_lut   = r_scr_lut;
    assign o_obj_valid = r_obj_valid;
    assign o_obj_code  = r_obj_code;
    assign o_obj_lut   = r_obj_lut;

endmodule

// File: rtl/jtkiwi_gfx_arb.sv
// Time-slot arbiter for the shared GFX read port of the tile code VRAM and
// the X1-001 LUT RAM. Holds the slot counter, grant logic and the registered
// address stage; read data returns through jtkiwi_arb_rdpipe 3 clocks after
// the grant.
// Optional build macro: JTKIWI_SLOT_STEAL_EN lets a requesting non-owner take
// a slot whose owner is idle (owner still wins when both request).
module jtkiwi_gfx_arb
    import jtkiwi_gfx_pkg::*;
#(
    parameter int CAW = 12,
    parameter int LAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           sync,
    input  logic           scr_req,
    input  logic [CAW-1:0] scr_caddr,
    input  logic [LAW-1:0] scr_laddr,
    output logic           scr_ack,
    output logic           scr_valid,
    output logic [15:0]    scr_code,
    output logic [7:0]     scr_lut,
    input  logic           obj_req,
    input  logic [CAW-1:0] obj_caddr,
    input  logic [LAW-1:0] obj_laddr,
    output logic           obj_ack,
    output logic           obj_valid,
    output logic [15:0]    obj_code,
    output logic [7:0]     obj_lut,
    output logic [CAW-1:0] code_addr,
    input  logic [15:0]    code_dout,
    output logic [LAW-1:0] lut_addr,
    input  logic [7:0]     lut_data,
    output logic [1:0]     slot
);

    logic [1:0]     r_slot;
    logic [CAW-1:0] r_code_addr;
    logic [LAW-1:0] r_lut_addr;
    logic           r_scr_ack;
    logic           r_obj_ack;

    logic           w_own;
    logic           w_own_req;
    logic           w_oth_req;
    logic           w_grant;
    logic           w_gnt_owner;
    logic           w_gnt_scr;
    logic           w_gnt_obj;
    arb_tag_t       w_tag;

    assign w_own     = slot_owner(r_slot);
    assign w_own_req = (w_own == OWN_OBJ) ? obj_req : scr_req;
    assign w_oth_req = (w_own == OWN_OBJ) ? scr_req : obj_req;

    // Grant decision: only on a slot advance that is not a line-start sync.
    always_comb begin
        w_grant     = 1'b0;
        w_gnt_owner = w_own;
        if (cen && !sync) begin
            if (w_own_req) begin
                w_grant = 1'b1;
            end
`ifdef JTKIWI_SLOT_STEAL_EN
            else if (w_oth_req) begin
                w_grant     = 1'b1;
                w_gnt_owner = ~w_own;
            end
`endif
        end
    end

`ifndef JTKIWI_SLOT_STEAL_EN
    // Non-owner request only matters when slot stealing is built in.
    logic w_unused_oth;
    assign w_unused_oth = w_oth_req;
`endif

    assign w_gnt_scr = w_grant && (w_gnt_owner == OWN_SCR);
    assign w_gnt_obj = w_grant && (w_gnt_owner == OWN_OBJ);
    assign w_tag     = '{active: w_grant, owner: w_gnt_owner};

    // Slot counter: sync restarts the sequence, cen advances it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= 2'd0;
        end else if (sync) begin
            r_slot <= 2'd0;
        end else if (cen) begin
            r_slot <= r_slot + 2'd1;
        end
    end

    // Address stage and acknowledges; an ungranted slot drives address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_addr <= '0;
            r_lut_addr  <= '0;
            r_scr_ack   <= 1'b0;
            r_obj_ack   <= 1'b0;
        end else begin
            r_scr_ack <= w_gnt_scr;
            r_obj_ack <= w_gnt_obj;
            if (cen) begin
                if (w_gnt_scr) begin
                    r_code_addr <= scr_caddr;
                    r_lut_addr  <= scr_laddr;
                end else if (w_gnt_obj) begin
                    r_code_addr <= obj_caddr;
                    r_lut_addr  <= obj_laddr;
                end else begin
                    r_code_addr <= '0;
                    r_lut_addr  <= '0;
                end
            end
        end
    end

    jtkiwi_arb_rdpipe u_rdpipe (
        .clk         (clk),
        .rst         (rst),
        .i_tag       (w_tag),
        .i_code      (code_dout),
        .i_lut       (lut_data),
        .o_scr_valid (scr_valid),
        .o_scr_code  (scr_code),
        .o_scr_lut   (scr_lut),
        .o_obj_valid (obj_valid),
        .o_obj_code  (obj_code),
        .o_obj_lut   (obj_lut)
    );

    assign slot      = r_slot;
    assign code_addr = r_code_addr;
    assign lut_addr  = r_lut_addr;
    assign scr_ack   = r_scr_ack;
    assign obj_ack   = r_obj_ack;

endmodule
